// File: rtl/mem_port_arbiter.sv
// Merges the instruction and data MemPorts onto one downstream MemPort with
// round-robin arbitration, request locking and saturating grant/contention counters.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  i_valid,
    output logic                  i_ready,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic [DATA_W-1:0]     i_rdata,

    input  logic                  d_valid,
    output logic                  d_ready,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic                  d_write_en,
    input  logic [DATA_W/8-1:0]   d_byte_en,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic [DATA_W-1:0]     d_rdata,

    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [ADDR_W-1:0]     m_addr,
    output logic                  m_write_en,
    output logic [DATA_W/8-1:0]   m_byte_en,
    output logic [DATA_W-1:0]     m_wdata,
    input  logic [DATA_W-1:0]     m_rdata,

    output logic [CNT_W-1:0]      cnt_i_grant,
    output logic [CNT_W-1:0]      cnt_d_grant,
    output logic [CNT_W-1:0]      cnt_conflict
);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_D} state_t;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;   // 1: data master won last
    logic              resp_sel_q, resp_sel_d;       // 1: response belongs to data master
    logic              resp_pend_q, resp_pend_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic              sel_d;
    logic              sel_valid;
    logic              xfer;

    // A locked owner is kept until m_ready; a fresh choice is only made in IDLE.
    always_comb begin
        sel_d     = 1'b0;
        sel_valid = 1'b0;
        case (state_q)
            LOCK_I: sel_valid = i_valid;
            LOCK_D: begin
                sel_d     = 1'b1;
                sel_valid = d_valid;
            end
            default: begin
                sel_valid = i_valid | d_valid;
                sel_d     = d_valid & (~i_valid | ~last_grant_q);
            end
        endcase
    end

    assign m_valid    = rst_n & sel_valid;
    assign xfer       = m_valid & m_ready;
    assign i_ready    = m_valid & ~sel_d & m_ready;
    assign d_ready    = m_valid & sel_d & m_ready;
    assign m_addr     = sel_d ? d_addr : i_addr;
    assign m_write_en = sel_d & d_write_en;
    assign m_byte_en  = sel_d ? d_byte_en : '1;
    assign m_wdata    = sel_d ? d_wdata : '0;

    always_comb begin
        state_d      = IDLE;
        last_grant_d = last_grant_q;
        resp_sel_d   = resp_sel_q;
        resp_pend_d  = xfer;
        if (xfer) begin
            last_grant_d = sel_d;
            resp_sel_d   = sel_d;
        end else if (m_valid) begin
            state_d = sel_d ? LOCK_D : LOCK_I;
        end
        i_rdata_d = (resp_pend_q && !resp_sel_q) ? m_rdata : i_rdata_q;
        d_rdata_d = (resp_pend_q &&  resp_sel_q) ? m_rdata : d_rdata_q;
    end

    // Returned data passes straight through on its cycle and is held afterwards.
    assign i_rdata = i_rdata_d;
    assign d_rdata = d_rdata_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b0;
            resp_sel_q   <= 1'b0;
            resp_pend_q  <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            resp_sel_q   <= resp_sel_d;
            resp_pend_q  <= resp_pend_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    logic [2:0]         cnt_inc;
    logic [3*CNT_W-1:0] cnt_flat;

    assign cnt_inc = {i_valid & d_valid, d_ready & d_valid, i_ready & i_valid};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (cnt_inc[gi] && (cnt_q != '1)) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign cnt_flat[gi*CNT_W +: CNT_W] = cnt_q;
        end
    endgenerate

    assign cnt_i_grant  = cnt_flat[0*CNT_W +: CNT_W];
    assign cnt_d_grant  = cnt_flat[1*CNT_W +: CNT_W];
    assign cnt_conflict = cnt_flat[2*CNT_W +: CNT_W];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand-written corner sequences
// and random traffic, all checked against a transaction-level reference model.
module tb_mem_port_arbiter;
    localparam logic [31:0] IA = 32'h1000_0000;
    localparam logic [31:0] DA = 32'h2000_0000;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, i_valid, d_valid, d_write_en, m_ready;
    logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
    logic [3:0]  d_byte_en;

    logic        i_ready, d_ready, m_valid, m_write_en;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
    logic [3:0]  m_byte_en;
    logic [31:0] cnt_i_grant, cnt_d_grant, cnt_conflict;

    logic        s_i_ready, s_d_ready, s_m_valid, s_m_write_en;
    logic [31:0] s_i_rdata, s_d_rdata, s_m_addr, s_m_wdata;
    logic [3:0]  s_m_byte_en;
    logic [3:0]  s_cnt_i, s_cnt_d, s_cnt_c;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(32)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr), .i_rdata(i_rdata),
        .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr), .d_write_en(d_write_en),
        .d_byte_en(d_byte_en), .d_wdata(d_wdata), .d_rdata(d_rdata),
        .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_write_en(m_write_en),
        .m_byte_en(m_byte_en), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .cnt_i_grant(cnt_i_grant), .cnt_d_grant(cnt_d_grant), .cnt_conflict(cnt_conflict)
    );

    // Narrow-counter instance to exercise saturation.
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .i_valid(i_valid), .i_ready(s_i_ready), .i_addr(i_addr), .i_rdata(s_i_rdata),
        .d_valid(d_valid), .d_ready(s_d_ready), .d_addr(d_addr), .d_write_en(d_write_en),
        .d_byte_en(d_byte_en), .d_wdata(d_wdata), .d_rdata(s_d_rdata),
        .m_valid(s_m_valid), .m_ready(m_ready), .m_addr(s_m_addr), .m_write_en(s_m_write_en),
        .m_byte_en(s_m_byte_en), .m_wdata(s_m_wdata), .m_rdata(m_rdata),
        .cnt_i_grant(s_cnt_i), .cnt_d_grant(s_cnt_d), .cnt_conflict(s_cnt_c)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endtask

    // Reference model: owner 0=none, 1=instruction, 2=data.
    int          lock_own, last_own, resp_who;
    bit          resp_pend;
    logic [31:0] i_hold, d_hold;
    longint      tot_i, tot_d, tot_c;

    function automatic longint sat(input longint v, input int w);
        longint top;
        top = (longint'(1) << w) - 1;
        return (v > top) ? top : v;
    endfunction

    task automatic model_reset();
        lock_own = 0; last_own = 1; resp_who = 1; resp_pend = 0;
        i_hold = '0; d_hold = '0;
        tot_i = 0; tot_d = 0; tot_c = 0;
    endtask

    task automatic model_step();
        int          cand;
        bit          act, e_ir, e_dr;
        logic [31:0] e_ird, e_drd, e_addr, e_wd;
        logic [3:0]  e_be;
        logic        e_we;
        if (lock_own != 0) begin
            cand = lock_own;
            act  = (cand == 1) ? i_valid : d_valid;
        end else if (i_valid && d_valid) begin
            cand = (last_own == 1) ? 2 : 1;
            act  = 1;
        end else if (d_valid) begin
            cand = 2; act = 1;
        end else if (i_valid) begin
            cand = 1; act = 1;
        end else begin
            cand = 0; act = 0;
        end
        if (!rst_n) act = 0;
        e_ir   = act && (cand == 1) && m_ready;
        e_dr   = act && (cand == 2) && m_ready;
        e_addr = (cand == 2) ? d_addr : i_addr;
        e_we   = (cand == 2) ? d_write_en : 1'b0;
        e_be   = (cand == 2) ? d_byte_en : 4'hF;
        e_wd   = (cand == 2) ? d_wdata : 32'h0;
        e_ird  = (resp_pend && resp_who == 1) ? m_rdata : i_hold;
        e_drd  = (resp_pend && resp_who == 2) ? m_rdata : d_hold;

        chk("m_valid", m_valid, act);
        chk("i_ready", i_ready, e_ir);
        chk("d_ready", d_ready, e_dr);
        chk("s_m_valid", s_m_valid, act);
        chk("s_i_ready", s_i_ready, e_ir);
        chk("s_d_ready", s_d_ready, e_dr);
        if (act) begin
            chk("m_addr", m_addr, e_addr);
            chk("m_write_en", m_write_en, e_we);
            chk("m_byte_en", m_byte_en, e_be);
            chk("m_wdata", m_wdata, e_wd);
            chk("s_m_addr", s_m_addr, e_addr);
            chk("s_m_write_en", s_m_write_en, e_we);
            chk("s_m_byte_en", s_m_byte_en, e_be);
            chk("s_m_wdata", s_m_wdata, e_wd);
        end
        chk("i_rdata", i_rdata, e_ird);
        chk("d_rdata", d_rdata, e_drd);
        chk("s_i_rdata", s_i_rdata, e_ird);
        chk("s_d_rdata", s_d_rdata, e_drd);
        chk("cnt_i_grant", cnt_i_grant, sat(tot_i, 32));
        chk("cnt_d_grant", cnt_d_grant, sat(tot_d, 32));
        chk("cnt_conflict", cnt_conflict, sat(tot_c, 32));
        chk("s_cnt_i", s_cnt_i, sat(tot_i, 4));
        chk("s_cnt_d", s_cnt_d, sat(tot_d, 4));
        chk("s_cnt_c", s_cnt_c, sat(tot_c, 4));

        if (!rst_n) begin
            model_reset();
        end else begin
            i_hold = e_ird;
            d_hold = e_drd;
            if (i_valid && d_valid) tot_c++;
            if (e_ir) tot_i++;
            if (e_dr) tot_d++;
            resp_pend = e_ir || e_dr;
            if (e_ir || e_dr) begin
                resp_who = cand;
                last_own = cand;
                lock_own = 0;
            end else begin
                lock_own = act ? cand : 0;
            end
        end
    endtask

    task automatic sample();
        @(negedge clk);
        model_step();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rn, input logic iv, input logic dv,
                         input logic we, input logic mr, input logic [31:0] rd);
        rst_n = rn; i_valid = iv; d_valid = dv; d_write_en = we; m_ready = mr; m_rdata = rd;
        i_addr = IA; d_addr = DA; d_byte_en = 4'h3; d_wdata = 32'h0000_1234;
    endtask

    typedef struct {
        logic        iv, dv, we, mr;
        logic [31:0] rd;
        logic        mv, ir, dr;
        logic [31:0] addr;
        logic        mwe;
        logic [3:0]  mbe;
        logic [31:0] mwd, ird, drd;
    } vec_t;

    vec_t tbl [16];

    initial begin
        // single master, conflict alternation, lock, write-then-read routing
        tbl[0]  = '{1'b1,1'b0,1'b0,1'b1,32'h0,        1'b1,1'b1,1'b0,IA,1'b0,4'hF,32'h0,    32'h0,        32'h0};
        tbl[1]  = '{1'b0,1'b0,1'b0,1'b1,32'hDEADBEEF, 1'b0,1'b0,1'b0,IA,1'b0,4'hF,32'h0,    32'hDEADBEEF, 32'h0};
        tbl[2]  = '{1'b1,1'b1,1'b0,1'b1,32'h0,        1'b1,1'b0,1'b1,DA,1'b0,4'h3,32'h1234, 32'hDEADBEEF, 32'h0};
        tbl[3]  = '{1'b1,1'b1,1'b0,1'b1,32'hA1,       1'b1,1'b1,1'b0,IA,1'b0,4'hF,32'h0,    32'hDEADBEEF, 32'hA1};
        tbl[4]  = '{1'b1,1'b1,1'b0,1'b1,32'hB2,       1'b1,1'b0,1'b1,DA,1'b0,4'h3,32'h1234, 32'hB2,       32'hA1};
        tbl[5]  = '{1'b1,1'b1,1'b0,1'b1,32'hC3,       1'b1,1'b1,1'b0,IA,1'b0,4'hF,32'h0,    32'hB2,       32'hC3};
        tbl[6]  = '{1'b0,1'b0,1'b0,1'b1,32'hD4,       1'b0,1'b0,1'b0,IA,1'b0,4'hF,32'h0,    32'hD4,       32'hC3};
        tbl[7]  = '{1'b0,1'b1,1'b0,1'b0,32'h0,        1'b1,1'b0,1'b0,DA,1'b0,4'h3,32'h1234, 32'hD4,       32'hC3};
        tbl[8]  = '{1'b1,1'b1,1'b0,1'b0,32'h0,        1'b1,1'b0,1'b0,DA,1'b0,4'h3,32'h1234, 32'hD4,       32'hC3};
        tbl[9]  = '{1'b1,1'b1,1'b0,1'b0,32'h0,        1'b1,1'b0,1'b0,DA,1'b0,4'h3,32'h1234, 32'hD4,       32'hC3};
        tbl[10] = '{1'b1,1'b1,1'b0,1'b1,32'h0,        1'b1,1'b0,1'b1,DA,1'b0,4'h3,32'h1234, 32'hD4,       32'hC3};
        tbl[11] = '{1'b1,1'b0,1'b0,1'b1,32'hE5,       1'b1,1'b1,1'b0,IA,1'b0,4'hF,32'h0,    32'hD4,       32'hE5};
        tbl[12] = '{1'b0,1'b0,1'b0,1'b1,32'hF6,       1'b0,1'b0,1'b0,IA,1'b0,4'hF,32'h0,    32'hF6,       32'hE5};
        tbl[13] = '{1'b0,1'b1,1'b1,1'b1,32'h0,        1'b1,1'b0,1'b1,DA,1'b1,4'h3,32'h1234, 32'hF6,       32'hE5};
        tbl[14] = '{1'b1,1'b0,1'b0,1'b1,32'h77,       1'b1,1'b1,1'b0,IA,1'b0,4'hF,32'h0,    32'hF6,       32'h77};
        tbl[15] = '{1'b0,1'b0,1'b0,1'b1,32'h88,       1'b0,1'b0,1'b0,IA,1'b0,4'hF,32'h0,    32'h88,       32'h77};

        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // reset state, still in reset
        sample();
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_cnt_i", cnt_i_grant, 32'd0);
        chk("rst_i_rdata", i_rdata, 32'd0);
        advance();

        for (int k = 0; k < 16; k++) begin
            drive(1'b1, tbl[k].iv, tbl[k].dv, tbl[k].we, tbl[k].mr, tbl[k].rd);
            sample();
            chk("tbl_m_valid", m_valid, tbl[k].mv);
            chk("tbl_i_ready", i_ready, tbl[k].ir);
            chk("tbl_d_ready", d_ready, tbl[k].dr);
            if (tbl[k].mv) begin
                chk("tbl_m_addr", m_addr, tbl[k].addr);
                chk("tbl_m_write_en", m_write_en, tbl[k].mwe);
                chk("tbl_m_byte_en", m_byte_en, tbl[k].mbe);
                chk("tbl_m_wdata", m_wdata, tbl[k].mwd);
            end
            chk("tbl_i_rdata", i_rdata, tbl[k].ird);
            chk("tbl_d_rdata", d_rdata, tbl[k].drd);
            $display("vec %0d: m_valid=%b i_ready=%b d_ready=%b m_addr=%h i_rdata=%h d_rdata=%h",
                     k, m_valid, i_ready, d_ready, m_addr, i_rdata, d_rdata);
            advance();
        end

        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        sample();
        chk("tot_cnt_i", cnt_i_grant, 32'd5);
        chk("tot_cnt_d", cnt_d_grant, 32'd4);
        chk("tot_cnt_conflict", cnt_conflict, 32'd7);
        $display("counters: i=%0d d=%0d conflict=%0d", cnt_i_grant, cnt_d_grant, cnt_conflict);
        advance();

        // reset while locked on D, with D having won the last grant
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
        sample(); advance();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        sample();
        chk("lock_m_valid", m_valid, 1'b1);
        advance();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        sample();
        chk("inrst_m_valid", m_valid, 1'b0);
        chk("inrst_d_ready", d_ready, 1'b0);
        advance();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h99);
        sample();
        chk("postrst_m_valid", m_valid, 1'b0);
        chk("postrst_cnt_d", cnt_d_grant, 32'd0);
        chk("postrst_cnt_c", cnt_conflict, 32'd0);
        chk("postrst_d_rdata", d_rdata, 32'd0);
        chk("postrst_i_rdata", i_rdata, 32'd0);
        $display("reset mid-lock: m_valid=%b d_rdata=%h cnt_d=%0d", m_valid, d_rdata, cnt_d_grant);
        advance();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0);
        sample();
        chk("postrst_first_d_ready", d_ready, 1'b1);
        chk("postrst_first_i_ready", i_ready, 1'b0);
        advance();

        // 20 further data grants saturate the 4-bit counter
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
            sample(); advance();
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        sample();
        chk("sat_cnt_d4", s_cnt_d, 4'd15);
        chk("wide_cnt_d", cnt_d_grant, 32'd21);
        $display("saturation: cnt_d(4b)=%0d cnt_d(32b)=%0d", s_cnt_d, cnt_d_grant);
        advance();

        // random traffic against the model
        for (int k = 0; k < 800; k++) begin
            rst_n      = ($urandom_range(0, 79) != 0);
            i_valid    = ($urandom_range(0, 2) != 0);
            d_valid    = ($urandom_range(0, 2) != 0);
            d_write_en = $urandom_range(0, 1) == 1;
            m_ready    = ($urandom_range(0, 3) != 0);
            m_rdata    = $urandom;
            i_addr     = $urandom;
            d_addr     = $urandom;
            d_wdata    = $urandom;
            d_byte_en  = 4'($urandom_range(0, 15));
            sample();
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
